hazard_sequencer: RTL and testbench

- Central stall/flush controller for the 5-stage MIPS pipeline: drives write-enables and flushes of PC, IF/ID, ID/EX and EX/MEM registers.
- Handles three events: load-use hazards (ID vs EX), taken branches resolved in MEM, and multi-cycle data-memory waits (req/ready).
- Sits beside the pipeline registers; their enables and flushes come only from this block.

---
 rtl/hazard_sequencer_if.sv | 44 ++++
 rtl/hazard_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_hazard_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// hazard_sequencer_if
// Groups the hazard inputs that the 5-stage pipeline reports and the
// register enable/flush controls that the sequencer drives back.
//   master : pipeline side (drives hazard info, receives controls)
//   slave  : sequencer side (receives hazard info, drives controls)
// Signals:
//   id_rs, id_rt, id_uses_rt     ID-stage source registers
//   ex_regdst, ex_mem_read       EX-stage load destination
//   mem_branch_taken             branch resolved taken in MEM
//   mem_req, mem_ready           data-memory handshake in MEM
//   pc_write .. exmem_flush      pipeline register enables / bubbles
//   mem_err                      sticky memory timeout flag
interface hazard_sequencer_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] ex_regdst;
  logic       ex_mem_read;
  logic       mem_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_flush;
  logic       exmem_write;
  logic       exmem_flush;
  logic       mem_err;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_regdst, ex_mem_read,
           mem_branch_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, mem_err
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_regdst, ex_mem_read,
           mem_branch_taken, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, exmem_flush, mem_err
  );
endinterface

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// Stall/flush controller for the 5-stage MIPS pipeline. Resolves three
// events with fixed priority (memory wait > taken branch > load-use) and
// drives the write-enables and flushes of the PC, IF/ID, ID/EX and EX/MEM
// registers. Outputs are combinational from registered state plus the
// current hazard inputs.
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   hz            hazard_sequencer_if.slave (hazard inputs, controls out)
//   stall_cycles  (HAZARD_PERF_EN only) saturating count of pc_write=0 cycles
//   flush_count   (HAZARD_PERF_EN only) saturating count of branch flushes
// Parameters:
//   LOAD_LAT      stall cycles per load-use hazard (1..15)
//   MEM_TIMEOUT   MEM_WAIT cycles before forced release + mem_err (1..65535)
// Optional feature macro: HAZARD_PERF_EN
module hazard_sequencer #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_sequencer_if.slave   hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [15:0]         flush_count
`endif
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;
  typedef enum logic [1:0] {ACT_DEFAULT, ACT_FREEZE, ACT_FLUSH, ACT_STALL} act_t;

  state_t      state;
  state_t      state_next;
  act_t        act;
  logic [3:0]  lcnt;
  logic [3:0]  lcnt_next;
  logic [15:0] wcnt;
  logic [15:0] wcnt_next;
  logic [16:0] wcnt_inc;
  logic        mem_err_q;
  logic        mem_err_next;
  logic        load_use;
  logic        mem_wait;

  assign load_use = hz.ex_mem_read && (hz.ex_regdst != 5'd0) &&
                    ((hz.ex_regdst == hz.id_rs) ||
                     (hz.id_uses_rt && (hz.ex_regdst == hz.id_rt)));
  // mem_ready only matters while a request is outstanding.
  assign mem_wait = hz.mem_req && !hz.mem_ready;
  assign wcnt_inc = {1'b0, wcnt} + 17'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      lcnt      <= 4'd0;
      wcnt      <= 16'd0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      lcnt      <= lcnt_next;
      wcnt      <= wcnt_next;
      mem_err_q <= mem_err_next;
    end
  end

  // Next-state and action selection
  always_comb begin
    state_next   = state;
    lcnt_next    = lcnt;
    wcnt_next    = wcnt;
    mem_err_next = mem_err_q;
    act          = ACT_DEFAULT;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            act        = ACT_FREEZE;
            state_next = MEM_WAIT;
            wcnt_next  = 16'd1;
          end else if (hz.mem_branch_taken) begin
            act = ACT_FLUSH;
          end else if (load_use) begin
            act = ACT_STALL;
            if (LOAD_LAT > 1) begin
              state_next = LOAD_STALL;
              lcnt_next  = 4'(LOAD_LAT - 1);
            end
          end
        end
        LOAD_STALL: begin
          if (mem_wait) begin
            // Remaining stall cycles are dropped; the frozen pipeline
            // re-presents any hazard once the wait clears.
            act        = ACT_FREEZE;
            state_next = MEM_WAIT;
            wcnt_next  = 16'd1;
            lcnt_next  = 4'd0;
          end else if (hz.mem_branch_taken) begin
            act        = ACT_FLUSH;
            state_next = RUN;
            lcnt_next  = 4'd0;
          end else begin
            act = ACT_STALL;
            if (lcnt <= 4'd1) begin
              state_next = RUN;
              lcnt_next  = 4'd0;
            end else begin
              lcnt_next = lcnt - 4'd1;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_wait) begin
            // The RUN cycle that entered the wait already counted as one,
            // so expiry is detected on the cycle the count would reach
            // MEM_TIMEOUT; that cycle is released instead of frozen.
            if (wcnt_inc >= 17'(MEM_TIMEOUT)) begin
              mem_err_next = 1'b1;
              state_next   = RUN;
              wcnt_next    = 16'd0;
            end else begin
              act       = ACT_FREEZE;
              wcnt_next = wcnt_inc[15:0];
            end
          end else begin
            state_next = RUN;
            wcnt_next  = 16'd0;
          end
        end
        default: begin
          state_next = RUN;
          lcnt_next  = 4'd0;
          wcnt_next  = 16'd0;
        end
      endcase
    end
  end

  // Action decode to register controls
  always_comb begin
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_write  = 1'b1;
    hz.idex_flush  = 1'b0;
    hz.exmem_write = 1'b1;
    hz.exmem_flush = 1'b0;
    case (act)
      ACT_FREEZE: begin
        hz.pc_write    = 1'b0;
        hz.ifid_write  = 1'b0;
        hz.idex_write  = 1'b0;
        hz.exmem_write = 1'b0;
      end
      ACT_FLUSH: begin
        hz.ifid_flush  = 1'b1;
        hz.idex_flush  = 1'b1;
        hz.exmem_flush = 1'b1;
      end
      ACT_STALL: begin
        hz.pc_write   = 1'b0;
        hz.ifid_write = 1'b0;
        hz.idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz.mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  // Performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
      flush_count  <= 16'd0;
    end else begin
      if ((act == ACT_FREEZE || act == ACT_STALL) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if ((act == ACT_FLUSH) && (flush_count != '1))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer
// Directed bench for hazard_sequencer. Two instances share one stimulus:
//   dut_a : LOAD_LAT=1, MEM_TIMEOUT=255
//   dut_b : LOAD_LAT=3, MEM_TIMEOUT=4
// Inputs change 1 ns after the rising edge, outputs are sampled 1 ns later.
// Control vectors are packed as
//   {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush}
module tb_hazard_sequencer;
  localparam logic [6:0] DEF = 7'b1101010;
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] FLS = 7'b1111111;
  localparam logic [6:0] STL = 7'b0001110;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] ex_regdst;
  logic       ex_mem_read;
  logic       mem_branch_taken;
  logic       mem_req;
  logic       mem_ready;

  int checks;
  int failures;

  hazard_sequencer_if bus_a ();
  hazard_sequencer_if bus_b ();

  assign bus_a.id_rs = id_rs;
  assign bus_a.id_rt = id_rt;
  assign bus_a.id_uses_rt = id_uses_rt;
  assign bus_a.ex_regdst = ex_regdst;
  assign bus_a.ex_mem_read = ex_mem_read;
  assign bus_a.mem_branch_taken = mem_branch_taken;
  assign bus_a.mem_req = mem_req;
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.id_rs = id_rs;
  assign bus_b.id_rt = id_rt;
  assign bus_b.id_uses_rt = id_uses_rt;
  assign bus_b.ex_regdst = ex_regdst;
  assign bus_b.ex_mem_read = ex_mem_read;
  assign bus_b.mem_branch_taken = mem_branch_taken;
  assign bus_b.mem_req = mem_req;
  assign bus_b.mem_ready = mem_ready;

  logic [6:0] outs_a;
  logic [6:0] outs_b;
  assign outs_a = {bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush, bus_a.idex_write,
                   bus_a.idex_flush, bus_a.exmem_write, bus_a.exmem_flush};
  assign outs_b = {bus_b.pc_write, bus_b.ifid_write, bus_b.ifid_flush, bus_b.idex_write,
                   bus_b.idex_flush, bus_b.exmem_write, bus_b.exmem_flush};

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_a;
  logic [31:0] stall_b;
  logic [15:0] flush_a;
  logic [15:0] flush_b;
`endif

  hazard_sequencer #(.LOAD_LAT(1), .MEM_TIMEOUT(255)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus_a)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stall_a),
    .flush_count  (flush_a)
`endif
  );

  hazard_sequencer #(.LOAD_LAT(3), .MEM_TIMEOUT(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus_b)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stall_b),
    .flush_count  (flush_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 5'd1;
    id_rt = 5'd2;
    id_uses_rt = 1'b0;
    ex_regdst = 5'd0;
    ex_mem_read = 1'b0;
    mem_branch_taken = 1'b0;
    mem_req = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_in();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_use_rs(input logic [4:0] r);
    ex_mem_read = 1'b1;
    ex_regdst = r;
    id_rs = r;
  endtask

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_b0;
  logic [31:0] stall_a0;
  logic [15:0] flush_a0;
`endif

  initial begin
    checks = 0;
    failures = 0;
    clear_in();

    // Reset with hazards present: outputs stay default
    rst_n = 1'b0;
    load_use_rs(5'd8);
    mem_req = 1'b1;
    #1;
    check_eq("rst_outs_a", outs_a, DEF);
    check_eq("rst_outs_b", outs_b, DEF);
    tick();
    check_eq("rst_mem_err_a", bus_a.mem_err, 1'b0);
    check_eq("rst_mem_err_b", bus_b.mem_err, 1'b0);
    tick();
    rst_n = 1'b1;
    idle(1);

    // LOAD_LAT=1 load-use on rs: one stall cycle
    load_use_rs(5'd8);
    #1;
    check_eq("a_lu_stall", outs_a, STL);
    tick();
    clear_in();
    #1;
    check_eq("a_lu_after", outs_a, DEF);
    idle(4);

    // Back-to-back load-use on A: each gets its own stall
    load_use_rs(5'd7);
    #1;
    check_eq("a_b2b_1", outs_a, STL);
    tick();
    load_use_rs(5'd6);
    #1;
    check_eq("a_b2b_2", outs_a, STL);
    tick();
    clear_in();
    #1;
    check_eq("a_b2b_done", outs_a, DEF);
    idle(4);

    // Destination $0 never creates a hazard
    load_use_rs(5'd0);
    #1;
    check_eq("a_lu_r0", outs_a, DEF);
    check_eq("b_lu_r0", outs_b, DEF);
    idle(2);

    // LOAD_LAT=3 load-use on rt: three consecutive stall cycles
    ex_mem_read = 1'b1;
    ex_regdst = 5'd9;
    id_rt = 5'd9;
    id_rs = 5'd3;
    id_uses_rt = 1'b1;
    #1;
    check_eq("b_rt_stall0", outs_b, STL);
    tick();
    clear_in();
    #1;
    check_eq("b_rt_stall1", outs_b, STL);
    tick();
    #1;
    check_eq("b_rt_stall2", outs_b, STL);
    tick();
    #1;
    check_eq("b_rt_done", outs_b, DEF);
    idle(2);

    // Same rt match but the instruction does not read rt
    ex_mem_read = 1'b1;
    ex_regdst = 5'd9;
    id_rt = 5'd9;
    id_rs = 5'd3;
    id_uses_rt = 1'b0;
    #1;
    check_eq("b_rt_unused", outs_b, DEF);
    idle(2);

    // Branch and load-use together: flush wins, no stall afterwards
    load_use_rs(5'd4);
    mem_branch_taken = 1'b1;
    #1;
    check_eq("a_br_lu_flush", outs_a, FLS);
    check_eq("b_br_lu_flush", outs_b, FLS);
    tick();
    clear_in();
    #1;
    check_eq("a_br_lu_next", outs_a, DEF);
    check_eq("b_br_lu_next", outs_b, DEF);
    idle(2);

    // Memory wait of 4 cycles with branch held; B times out on the same stimulus
    clear_in();
    mem_req = 1'b1;
    mem_branch_taken = 1'b1;
`ifdef HAZARD_PERF_EN
    stall_a0 = stall_a;
    stall_b0 = stall_b;
    flush_a0 = flush_a;
`endif
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("a_freeze%0d", i), outs_a, FRZ);
      if (i < 3) check_eq($sformatf("b_freeze%0d", i), outs_b, FRZ);
      else check_eq("b_timeout_release", outs_b, DEF);
      tick();
    end
    check_eq("b_mem_err_set", bus_b.mem_err, 1'b1);
    check_eq("a_mem_err_clear", bus_a.mem_err, 1'b0);
`ifdef HAZARD_PERF_EN
    check_eq("b_stall_cycles", stall_b - stall_b0, 32'd3);
`endif
    mem_ready = 1'b1;
    #1;
    check_eq("a_ready_release", outs_a, DEF);
    tick();
    mem_req = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_eq("a_branch_after_release", outs_a, FLS);
    tick();
    mem_branch_taken = 1'b0;
    #1;
    check_eq("a_after_flush", outs_a, DEF);
`ifdef HAZARD_PERF_EN
    check_eq("a_stall_cycles", stall_a - stall_a0, 32'd4);
    check_eq("a_flush_count", 32'(flush_a - flush_a0), 32'd1);
`endif
    idle(3);
    check_eq("b_mem_err_sticky", bus_b.mem_err, 1'b1);

    // Reset in the middle of a wait (A has counted 5 wait cycles)
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    check_eq("a_rst_wait_outs", outs_a, DEF);
    check_eq("b_rst_wait_outs", outs_b, DEF);
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    mem_branch_taken = 1'b1;
    #1;
    check_eq("a_post_rst_run", outs_a, FLS);
    check_eq("b_post_rst_run", outs_b, FLS);
    check_eq("a_post_rst_err", bus_a.mem_err, 1'b0);
    check_eq("b_post_rst_err", bus_b.mem_err, 1'b0);
`ifdef HAZARD_PERF_EN
    check_eq("a_post_rst_stall", stall_a, 32'd0);
`endif
    tick();
    idle(2);

    // Wait preempts a LOAD_LAT=3 stall; leftover stall is dropped
    load_use_rs(5'd5);
    #1;
    check_eq("b_pre_stall", outs_b, STL);
    tick();
    clear_in();
    mem_req = 1'b1;
    #1;
    check_eq("b_preempt_freeze", outs_b, FRZ);
    tick();
    mem_ready = 1'b1;
    #1;
    check_eq("b_preempt_release", outs_b, DEF);
    tick();
    clear_in();
    #1;
    check_eq("b_preempt_no_stall", outs_b, DEF);
    idle(2);

    // Branch during LOAD_STALL: flush, then back to RUN
    load_use_rs(5'd5);
    #1;
    check_eq("b_stall_br0", outs_b, STL);
    tick();
    clear_in();
    mem_branch_taken = 1'b1;
    #1;
    check_eq("b_stall_br_flush", outs_b, FLS);
    tick();
    clear_in();
    #1;
    check_eq("b_stall_br_done", outs_b, DEF);
    idle(2);

    // mem_ready without mem_req is ignored
    mem_ready = 1'b1;
    load_use_rs(5'd12);
    #1;
    check_eq("a_ready_no_req", outs_a, STL);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
